// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read at a time and
// parks each returned word with its PC in an IF/ID slot under a valid/ready handshake.
// Redirects flush the slot and can kill a read that is already in flight.
// Optional build macro PC_ALIGN_CHECK_EN: a misaligned redirect target parks a NOP with
// inst_addr_err set and stops fetching until the next redirect. Without it, redirect
// targets are silently word-aligned and inst_addr_err is tied low.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inst_ready,
  output logic        inst_valid,
  output logic [31:0] inst_31_0,
  output logic [31:0] inst_pc,
  output logic        inst_addr_err
);

`ifdef PC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {StIdle, StReq, StRsp, StErr} state_e;
`else
  typedef enum logic [1:0] {StIdle, StReq, StRsp} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        kill_q, kill_d;
  logic        valid_q, valid_d;
  logic [31:0] data_q, data_d;
  logic [31:0] ipc_q, ipc_d;
  logic        slot_free;
  logic        rsp_pending;
  logic [31:0] redir_pc;

`ifdef PC_ALIGN_CHECK_EN
  logic        err_q, err_d;
  logic        misaligned;
  assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
  logic        unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
`endif

  // A new read may only be issued when the slot is empty or emptying this cycle,
  // so a returning word always has somewhere to land.
  assign slot_free = !valid_q || inst_ready;
  assign imem_req  = (state_q == StReq) && slot_free;
  assign imem_addr = pc_q;
  assign redir_pc  = {redirect_pc[31:2], 2'b00};

  // A read will still be outstanding after this cycle; a redirect must then wait it out
  // in StRsp with kill set, so that only one read is ever in flight.
`ifdef PC_ALIGN_CHECK_EN
  assign rsp_pending = ((state_q == StRsp) && !imem_rvalid) || (imem_req && imem_gnt) ||
                       ((state_q == StErr) && kill_q && !imem_rvalid);
`else
  assign rsp_pending = ((state_q == StRsp) && !imem_rvalid) || (imem_req && imem_gnt);
`endif

  // Next-state logic for the FSM, PC and output slot; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    kill_d     = kill_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ipc_d      = ipc_q;
`ifdef PC_ALIGN_CHECK_EN
    err_d      = err_q;
`endif

    if (valid_q && inst_ready) begin
      valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      err_d   = 1'b0;
`endif
    end

    case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_req && imem_gnt) begin
          pc_d       = pc_q + 32'd4;
          fetch_pc_d = pc_q;
          state_d    = StRsp;
        end
      end
      StRsp: begin
        if (imem_rvalid) begin
          if (!kill_q) begin
            valid_d = 1'b1;
            data_d  = imem_rdata;
            ipc_d   = fetch_pc_q;
`ifdef PC_ALIGN_CHECK_EN
            err_d   = 1'b0;
`endif
          end
          kill_d  = 1'b0;
          state_d = StReq;
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      // Parked on a bad target; only swallow a killed response still in flight.
      StErr: begin
        if (imem_rvalid) kill_d = 1'b0;
      end
`endif
      default: state_d = StIdle;
    endcase

    if (redirect_valid) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      kill_d  = rsp_pending;
      state_d = rsp_pending ? StRsp : StReq;
`ifdef PC_ALIGN_CHECK_EN
      err_d   = 1'b0;
      if (misaligned) begin
        state_d = StErr;
        valid_d = 1'b1;
        data_d  = 32'h0;
        ipc_d   = redirect_pc;
        err_d   = 1'b1;
      end
`endif
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      fetch_pc_q <= 32'h0;
      kill_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'h0;
      ipc_q      <= 32'h0;
`ifdef PC_ALIGN_CHECK_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      kill_q     <= kill_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ipc_q      <= ipc_d;
`ifdef PC_ALIGN_CHECK_EN
      err_q      <= err_d;
`endif
    end
  end

  assign inst_valid = valid_q;
  assign inst_31_0  = data_q;
  assign inst_pc    = ipc_q;
`ifdef PC_ALIGN_CHECK_EN
  assign inst_addr_err = err_q;
`else
  assign inst_addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a bench-side instruction memory with a grant budget
// and configurable latency, a scoreboard of expected {pc, word, err} checked on every
// accepted instruction, a table of redirect/fetch runs and hand sequences for the
// multi-cycle corner cases (backpressure, killed reads, wrap, reset, misaligned target).
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_ready;
  logic        inst_valid;
  logic [31:0] inst_31_0;
  logic [31:0] inst_pc;
  logic        inst_addr_err;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_ready     (inst_ready),
    .inst_valid     (inst_valid),
    .inst_31_0      (inst_31_0),
    .inst_pc        (inst_pc),
    .inst_addr_err  (inst_addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_first;
    int          lat;
    int          n;
    bit          stall;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Memory model state
  int          gnt_budget = 0;
  int          mem_lat    = 1;
  bit          mem_busy   = 0;
  int          mem_cnt    = 0;
  logic [31:0] mem_addr   = 32'h0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic void push_exp(input logic [31:0] p);
    sb.push_back('{pc: p, data: word_of(p), err: 1'b0});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Instruction memory: grants while budget remains and nothing is outstanding,
  // answers mem_lat cycles after the grant.
  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(mem_addr);
        mem_busy    = 0;
      end else begin
        mem_cnt--;
      end
    end
    imem_gnt = imem_req && !mem_busy && (gnt_budget > 0);
    if (imem_gnt) begin
      gnt_budget--;
      mem_busy = 1;
      mem_addr = imem_addr;
      mem_cnt  = mem_lat - 1;
    end
  end

  // Scoreboard: every accepted instruction must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_inst: got pc=%h word=%h, required no instruction",
                 inst_pc, inst_31_0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (inst_pc !== e.pc || inst_31_0 !== e.data || inst_addr_err !== e.err) begin
          n_fail++;
          $display("FAIL sb_inst: got pc=%h word=%h err=%b, required pc=%h word=%h err=%b",
                   inst_pc, inst_31_0, inst_addr_err, e.pc, e.data, e.err);
        end
      end
    end
  end

  // Run until the scoreboard empties; ends one tick later so callers start after posedge.
  task automatic drain(input string name, input int limit, input bit stall);
    bit ok;
    ok = 0;
    for (int c = 0; c < limit; c++) begin
      sample();
      if (sb.size() == 0) begin
        ok = 1;
        break;
      end
      tick();
      inst_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    check(name, 32'(ok), 32'd1);
    if (!ok) sb.delete();
    inst_ready = 1'b1;
    tick();
  endtask

  // Returns at the sample point of the granted cycle.
  task automatic wait_gnt(input string name);
    bit ok;
    ok = 0;
    for (int c = 0; c < 30; c++) begin
      sample();
      if (imem_gnt) begin
        ok = 1;
        break;
      end
      tick();
    end
    check(name, 32'(ok), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = 32'h0;

    vecs.push_back('{target: 32'h0000_1000, exp_first: 32'h0000_1000, lat: 1, n: 3, stall: 0});
    vecs.push_back('{target: 32'h0000_2000, exp_first: 32'h0000_2000, lat: 2, n: 4, stall: 1});
    vecs.push_back('{target: 32'hFFFF_FFF8, exp_first: 32'hFFFF_FFF8, lat: 1, n: 3, stall: 0});
    vecs.push_back('{target: 32'h8000_0000, exp_first: 32'h8000_0000, lat: 4, n: 2, stall: 1});
`ifndef PC_ALIGN_CHECK_EN
    vecs.push_back('{target: 32'h0000_0102, exp_first: 32'h0000_0100, lat: 1, n: 2, stall: 0});
    vecs.push_back('{target: 32'h0000_0FFF, exp_first: 32'h0000_0FFC, lat: 2, n: 2, stall: 0});
`endif

    // Reset state, then straight-line fetch 0,4,8,C at one instruction per two cycles
    tick();
    tick();
    rst_n      = 1'b1;
    gnt_budget = 4;
    for (int k = 0; k < 4; k++) push_exp(32'(4 * k));
    sample();
    check("rst_req", imem_req, 0);
    check("rst_valid", inst_valid, 0);
    check("rst_data", inst_31_0, 0);
    check("rst_pc", inst_pc, 0);
    check("rst_err", inst_addr_err, 0);
    tick();
    sample();
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      sample();
      check("t1_valid_pattern", inst_valid, 32'((i % 2) == 0));
      tick();
    end
    drain("t1_drain", 20, 0);

    // Backpressure: slot full with ready low holds the slot and suppresses requests
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    inst_ready     = 1'b0;
    tick();
    redirect_valid = 1'b0;
    mem_lat        = 1;
    gnt_budget     = 2;
    push_exp(32'h40);
    ok = 0;
    for (int c = 0; c < 20; c++) begin
      sample();
      if (inst_valid) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("t2_slot_filled", 32'(ok), 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        tick();
        sample();
      end
      check("t2_req_held_low", imem_req, 0);
      check("t2_slot_pc_stable", inst_pc, 32'h40);
    end
    tick();
    inst_ready = 1'b1;
    push_exp(32'h44);
    sample();
    check("t2_req_on_ready", imem_req, 1);
    check("t2_addr_on_ready", imem_addr, 32'h44);
    drain("t2_drain", 20, 0);

    // Redirect while a slow response is outstanding: the stale word must vanish
    mem_lat    = 3;
    gnt_budget = 1;
    wait_gnt("t3_gnt");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    gnt_budget     = 1;
    push_exp(32'h100);
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t3_no_stale_valid", inst_valid, 0);
      tick();
    end
    drain("t3_drain", 30, 0);

    // Redirect in the same cycle as rvalid: data dropped, refetch from the target
    mem_lat    = 1;
    gnt_budget = 1;
    wait_gnt("t4_gnt");
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    push_exp(32'h300);
    tick();
    redirect_valid = 1'b0;
    gnt_budget     = 1;
    sample();
    check("t4_req_after", imem_req, 1);
    check("t4_addr_after", imem_addr, 32'h300);
    check("t4_no_valid", inst_valid, 0);
    drain("t4_drain", 20, 0);

    // Redirect in the same cycle as a grant: the granted read is killed
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    gnt_budget     = 2;
    mem_lat        = 1;
    push_exp(32'h500);
    sample();
    check("t5_gnt_with_redirect", imem_gnt, 1);
    tick();
    redirect_valid = 1'b0;
    drain("t5_drain", 20, 0);

    // Table of redirect targets, latencies and backpressure patterns (includes PC wrap)
    foreach (vecs[k]) begin
      redirect_valid = 1'b1;
      redirect_pc    = vecs[k].target;
      tick();
      redirect_valid = 1'b0;
      mem_lat        = vecs[k].lat;
      gnt_budget     = vecs[k].n;
      for (int j = 0; j < vecs[k].n; j++) push_exp(vecs[k].exp_first + 32'(4 * j));
      drain("vec_drain", 300, vecs[k].stall);
    end

`ifdef PC_ALIGN_CHECK_EN
    // Misaligned target: NOP with error marker, held until taken, no fetching
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    inst_ready     = 1'b0;
    sb.push_back('{pc: 32'h102, data: 32'h0, err: 1'b1});
    tick();
    redirect_valid = 1'b0;
    gnt_budget     = 1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("err_valid", inst_valid, 1);
      check("err_flag", inst_addr_err, 1);
      check("err_nop", inst_31_0, 0);
      check("err_pc", inst_pc, 32'h102);
      check("err_no_req", imem_req, 0);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      sample();
      check("err_stays_idle_valid", inst_valid, 0);
      check("err_stays_idle_req", imem_req, 0);
      tick();
    end
    gnt_budget     = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_valid = 1'b0;
    gnt_budget     = 1;
    mem_lat        = 1;
    push_exp(32'h200);
    drain("err_resume_drain", 20, 0);
`endif

    // Reset mid-read: the stray response after reset must be ignored
    mem_lat    = 3;
    gnt_budget = 1;
    wait_gnt("rst_mid_gnt");
    tick();
    rst_n = 1'b0;
    tick();
    rst_n      = 1'b1;
    gnt_budget = 1;
    push_exp(32'h0);
    sample();
    check("rst_mid_valid", inst_valid, 0);
    check("rst_mid_req", imem_req, 0);
    check("rst_mid_pc", inst_pc, 0);
    tick();
    drain("rst_mid_drain", 30, 0);

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
